// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave front end: receives host command bytes into a first-word-fall-through
// FIFO for the controller and returns the controller's status byte on MISO.
module spi_cmd_frontend #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    output logic [7:0]                    in_byte,
    output logic                          in_ready,
    input  logic                          next,
    input  logic [7:0]                    spi_output,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES:0]   settle_reg;
    logic                   sck_d_reg;
    logic                   cs_d_reg;

    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   settled;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;

    logic                   armed_reg;
    logic [2:0]             bit_cnt_reg;
    logic [6:0]             rx_shift_reg;
    logic [7:0]             tx_shift_reg;

    logic                   push;
    logic [7:0]             push_data;
    logic                   pop_ok;
    logic                   push_ok;
    logic                   full;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [AW-1:0]          rd_ptr_next;
    logic [AW:0]            count_reg;
    logic [AW:0]            count_next;
    logic [7:0]             in_byte_reg;
    logic                   in_ready_reg;
    logic                   overflow_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_reg  <= '0;
            cs_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            settle_reg    <= '0;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            settle_reg    <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s   = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s    = cs_sync_reg[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_reg[SYNC_STAGES-1];

    // Edges are ignored until the chains have flushed their reset values, so a cs_n
    // held low across reset cannot fake a falling edge and arm mid-byte.
    assign settled  = settle_reg[SYNC_STAGES];
    assign sck_rise = settled &&  sck_s && !sck_d_reg;
    assign sck_fall = settled && !sck_s &&  sck_d_reg;
    assign cs_rise  = settled &&  cs_s  && !cs_d_reg;
    assign cs_fall  = settled && !cs_s  &&  cs_d_reg;

    assign push      = !cs_s && !cs_fall && armed_reg && sck_rise && (bit_cnt_reg == 3'd7);
    assign push_data = {rx_shift_reg, mosi_s};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_d_reg    <= 1'b0;
            cs_d_reg     <= 1'b1;
            armed_reg    <= 1'b0;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            tx_shift_reg <= 8'd0;
        end else begin
            sck_d_reg <= sck_s;
            cs_d_reg  <= cs_s;
            if (cs_fall) begin
                bit_cnt_reg  <= 3'd0;
                tx_shift_reg <= spi_output;
                armed_reg    <= 1'b1;
            end else if (cs_rise) begin
                bit_cnt_reg <= 3'd0;
            end else if (!cs_s) begin
                if (sck_rise && armed_reg) begin
                    rx_shift_reg <= push_data[6:0];
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_reg  <= 3'd0;
                        tx_shift_reg <= spi_output;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                end else if (sck_fall && bit_cnt_reg != 3'd0) begin
                    // Holding at the byte boundary keeps the freshly loaded MSB on miso.
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                end
            end
        end
    end

    assign miso = !cs_s && tx_shift_reg[7];

    always_comb begin
        pop_ok      = next && in_ready_reg;
        full        = (count_reg == FULL_COUNT);
        push_ok     = push && (!full || pop_ok);
        rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            in_byte_reg  <= 8'd0;
            in_ready_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            in_ready_reg <= (count_next != '0);
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            // Registered head: bypass the RAM when the new head is the byte being written now.
            if (count_next == '0) begin
                in_byte_reg <= 8'd0;
            end else if (push_ok && rd_ptr_next == wr_ptr_reg) begin
                in_byte_reg <= push_data;
            end else begin
                in_byte_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign in_byte    = in_byte_reg;
    assign in_ready   = in_ready_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Bench for spi_cmd_frontend: a host SPI driver plus a queue-based model of the command
// FIFO compared against the DUT every cycle, with literal expectations per scenario.
module tb_spi_cmd_frontend;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sck = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          next = 1'b0;
    logic [7:0]    spi_output = 8'h00;
    logic          miso;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    spi_cmd_frontend #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .in_byte(in_byte), .in_ready(in_ready), .next(next), .spi_output(spi_output),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
    } pend_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    pend_t      pend_q[$];
    logic [7:0] mq[$];
    bit         movf = 1'b0;
    logic [7:0] popped[$];
    bit         due_valid = 1'b0;
    int         due_cyc = 0;
    logic [7:0] g1, g2;
    bit         mpop, mpush;
    logic [7:0] mpb;
    pend_t      mp;
    logic [7:0] burst [4] = '{8'h02, 8'h07, 8'h12, 8'h34};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a byte completed at the pins enters the queue SYNC+1 edges after its last sck rise.
    always begin
        @(posedge clk);
        cyc++;
        if (!reset) begin
            mq.delete();
            pend_q.delete();
            movf = 1'b0;
        end else begin
            mpop  = next && (mq.size() != 0);
            mpush = 1'b0;
            mpb   = 8'h00;
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                mp    = pend_q.pop_front();
                mpush = 1'b1;
                mpb   = mp.data;
            end
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                if (mq.size() == DEPTH) movf = 1'b1;
                else mq.push_back(mpb);
            end
        end
        @(negedge clk);
        chk("in_ready", in_ready, mq.size() != 0);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, movf);
        if (mq.size() != 0) chk("in_byte", in_byte, mq[0]);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_n(6);
    endtask

    task automatic cs_high();
        sck = 1'b0;
        wait_n(4);
        cs_n = 1'b1;
        wait_n(6);
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits, input bit track,
                             output logic [7:0] got);
        pend_t p;
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck  = 1'b0;
            mosi = data[i];
            wait_n(4);
            got = {got[6:0], miso};
            sck = 1'b1;
            if (i == 0 && track) begin
                p.due  = cyc + SYNC + 1;
                p.data = data;
                pend_q.push_back(p);
                due_cyc   = p.due;
                due_valid = 1'b1;
            end
            wait_n(4);
        end
    endtask

    task automatic drain(input int n, input int gap, input int budget);
        int got_n = 0;
        int t = 0;
        while (got_n < n && t < budget) begin
            if (in_ready) begin
                popped.push_back(in_byte);
                next = 1'b1;
                wait_n(1);
                next = 1'b0;
                got_n++;
                wait_n(gap - 1);
                t += gap;
            end else begin
                wait_n(1);
                t++;
            end
        end
        chk("drain_done", got_n, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_in_byte"}, in_byte, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_miso"}, miso, 0);
    endtask

    task automatic apply_reset();
        cs_n = 1'b1;
        sck  = 1'b0;
        reset = 1'b0;
        wait_n(2);
        reset = 1'b1;
        wait_n(4);
    endtask

    initial begin
        wait_n(3);
        check_reset_outputs("por");
        reset = 1'b1;
        wait_n(4);

        // Basic receive and single pop
        cs_low();
        send_bits(8'hA5, 8, 1'b1, g1);
        chk("basic_ready", in_ready, 1);
        chk("basic_byte", in_byte, 8'hA5);
        chk("basic_count", fifo_count, 1);
        next = 1'b1;
        wait_n(1);
        next = 1'b0;
        chk("basic_pop", in_ready, 0);
        cs_high();

        // Status return
        spi_output = 8'h3C;
        cs_low();
        fork
            begin
                send_bits(8'h00, 8, 1'b1, g1);
                send_bits(8'hFF, 8, 1'b1, g2);
            end
            begin
                wait_n(20);
                spi_output = 8'h81;
            end
        join
        cs_high();
        chk("status_b0", g1, 8'h3C);
        chk("status_b1", g2, 8'h81);
        popped.delete();
        drain(2, 1, 200);
        if (popped.size() == 2) begin
            chk("status_rx0", popped[0], 8'h00);
            chk("status_rx1", popped[1], 8'hFF);
        end

        // Multi-byte burst with concurrent slow pops
        popped.delete();
        cs_low();
        fork
            begin
                for (int i = 0; i < 4; i++) send_bits(burst[i], 8, 1'b1, g1);
                cs_high();
            end
            drain(4, 3, 3000);
        join
        chk("burst_n", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("burst_byte", popped[i], burst[i]);
        chk("burst_empty", fifo_count, 0);

        // Overflow
        cs_low();
        for (int i = 0; i < DEPTH + 2; i++) send_bits(8'(8'h80 + i), 8, 1'b1, g1);
        cs_high();
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_flag", overflow, 1);
        popped.delete();
        drain(DEPTH, 1, 500);
        for (int i = 0; i < DEPTH && i < popped.size(); i++) chk("ovf_byte", popped[i], 8'(8'h80 + i));
        chk("ovf_sticky", overflow, 1);

        apply_reset();
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop in the same cycle
        cs_low();
        for (int i = 0; i < DEPTH; i++) send_bits(8'(8'h40 + i), 8, 1'b1, g1);
        chk("full_count", fifo_count, DEPTH);
        due_valid = 1'b0;
        fork
            send_bits(8'h99, 8, 1'b1, g1);
            begin
                wait (due_valid);
                for (int k = 0; k < 10 && cyc != due_cyc - 1; k++) wait_n(1);
                next = 1'b1;
                wait_n(1);
                next = 1'b0;
            end
        join
        cs_high();
        chk("pp_count", fifo_count, DEPTH);
        chk("pp_overflow", overflow, 0);
        popped.delete();
        drain(DEPTH, 1, 500);
        if (popped.size() == DEPTH) begin
            chk("pp_first", popped[0], 8'h41);
            chk("pp_last", popped[DEPTH-1], 8'h99);
        end

        // Abort mid-byte, then a clean byte
        cs_low();
        send_bits(8'hFF, 5, 1'b0, g1);
        cs_high();
        chk("abort_none", fifo_count, 0);
        cs_low();
        send_bits(8'h5A, 8, 1'b1, g1);
        cs_high();
        chk("abort_next_byte", in_byte, 8'h5A);
        chk("abort_next_count", fifo_count, 1);
        popped.delete();
        drain(1, 1, 100);

        // Reset mid-byte: disarmed until a fresh cs_n falling edge
        cs_low();
        send_bits(8'hC3, 4, 1'b0, g1);
        reset = 1'b0;
        wait_n(3);
        check_reset_outputs("midrst");
        reset = 1'b1;
        send_bits(8'hC3, 8, 1'b0, g1);
        send_bits(8'h77, 8, 1'b0, g1);
        chk("rst_none_count", fifo_count, 0);
        chk("rst_none_ready", in_ready, 0);
        cs_high();
        cs_low();
        send_bits(8'h11, 8, 1'b1, g1);
        cs_high();
        chk("rst_rearm_byte", in_byte, 8'h11);
        chk("rst_rearm_count", fifo_count, 1);
        popped.delete();
        drain(1, 1, 100);

        wait_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_frontend.md
Name: spi_cmd_frontend

Overview:
- SPI-slave byte front end that produces the command byte stream consumed by control_unit.
- Deserialises MOSI bytes from the host MCU into a small FIFO, presented on the `in_byte` / `in_ready` / `next` handshake.
- Simultaneously serialises the controller's `spi_output` status byte back to the host on MISO.
- Sits between the external SPI pins and control_unit, in the system clock domain.

Parameters:
- FIFO_DEPTH, 16, byte entries in the receive FIFO; must be a power of two, ≥2.
- SYNC_STAGES, 2, flip-flop stages on each of sck, cs_n and mosi before use; ≥2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- sck  input  1  SPI clock from host, asynchronous to clk.
- cs_n  input  1  SPI chip select, active-low, asynchronous.
- mosi  input  1  SPI data from host, asynchronous.
- miso  output  1  SPI data to host.
- in_byte  output  8  FIFO head byte to the controller.
- in_ready  output  1  high while FIFO non-empty.
- next  input  1  controller pop strobe, one cycle per byte.
- spi_output  input  8  status byte to be returned to the host.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a received byte was dropped because the FIFO was full.

Behaviour:
- Clock ratio: clk ≥ 4× sck frequency. Slower clk is unsupported.
- Synchronisation:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage against one further registered copy.
  - All logic uses only the synchronised signals.
- SPI mode 0, MSB first: sample mosi on the synced sck rising edge; shift miso on the synced sck falling edge.
- Arming:
  - After reset release, the receiver is disarmed until a synced cs_n falling edge.
  - Bytes in progress during or before reset are never delivered.
- Synced cs_n falling edge:
  - bit_cnt <= 0.
  - tx_shift <= spi_output.
  - Receiver armed.
- Synced sck rising edge while cs_n low and armed:
  - rx_shift <= {rx_shift[6:0], mosi}.
  - bit_cnt increments.
  - On the 8th bit:
    - Push {rx_shift[6:0], mosi} into the FIFO.
    - bit_cnt <= 0.
    - tx_shift <= spi_output, sampled that cycle.
- Synced sck falling edge while cs_n low: if bit_cnt != 0, tx_shift <= {tx_shift[6:0], 1'b0}. No shift at a byte boundary, so bit 7 of the reloaded byte stays on miso.
- miso = tx_shift[7] while synced cs_n is low; 0 otherwise. The pin is never tristated.
- cs_n rising edge mid-byte: the partial byte is discarded and bit_cnt <= 0. No push occurs.
- FIFO behaviour:
  - First-word-fall-through; `in_byte` is the head entry.
  - `in_ready` = (fifo_count != 0), registered.
  - A pushed byte is visible on in_byte with in_ready=1 in the cycle after the push.
  - End-to-end latency: no more than SYNC_STAGES+3 clk cycles after the 8th sck rising edge at the pin.
- Pop rules:
  - next=1 with in_ready=1: pops. The new head (or in_ready=0) appears the following cycle.
  - next=1 with in_ready=0: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Push to a full FIFO:
  - With simultaneous pop: both occur and count is unchanged.
  - Without pop: the byte is dropped and overflow <= 1. overflow clears only on reset.
- Push and pop in the same cycle with the FIFO empty: the push is accepted and the pop is ignored.
- Reset values (reset=0 at a clk edge), for every output and key state element:
  - Outputs: in_ready=0, in_byte=0, fifo_count=0, overflow=0, miso=0.
  - Internal state: bit_cnt=0, tx_shift=0, rx_shift=0, FIFO pointers=0, disarmed.
  - Sync flops reset to cs_n=1, sck=0, mosi=0.

Test Plan:
- Basic receive:
  - Stimulus: cs_n low, send 0xA5 at clk/8.
  - Response: in_ready rises within SYNC_STAGES+3 cycles of the 8th sck rise, in_byte=0xA5, fifo_count=1. A one-cycle next then gives in_ready=0 on the next cycle.
- Status return:
  - Stimulus: spi_output=0x3C before cs_n falls; then 0x81 during byte 1; host clocks two bytes.
  - Response: host samples 0x3C, then 0x81 on miso.
- Multi-byte burst:
  - Stimulus: send 0x02,0x07,0x12,0x34 (a WRITE_BLOCK_REG-style sequence) with next pulsed every 3 cycles while in_ready=1.
  - Response: bytes emerge in order, no duplicates, fifo_count returns to 0.
- Overflow:
  - Stimulus: send FIFO_DEPTH+2 bytes with next held 0.
  - Response: fifo_count=FIFO_DEPTH, overflow=1, and the first FIFO_DEPTH bytes are delivered intact on drain.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, a byte completes in the same cycle as next.
  - Response: count unchanged, overflow stays 0, the new byte ends up last.
- Abort and reset:
  - cs_n rises after 5 bits: nothing pushed. The following full byte 0x5A is received correctly.
  - reset=0 mid-byte, then released: all outputs at reset values. No byte is delivered until a new cs_n falling edge, after which 0x11 is received.
